// File: rtl/mem_if_pkg.sv
// Shared types and geometry for the 128x52 register-file bus responder.
// Optional feature WRITE_THROUGH_EN is consumed by rf_mem_responder.
package mem_if_pkg;

    localparam int DW    = 52;
    localparam int RA_W  = 5;
    localparam int CA_W  = 2;
    localparam int AW    = RA_W + CA_W;
    localparam int DEPTH = 128;

    typedef enum logic {
        CLEAR,
        SERVE
    } state_t;

    typedef enum logic [1:0] {
        IDLE,
        READ,
        WRITE
    } cmd_t;

    // An unknown NCE fails the == test and falls through to IDLE
    function automatic cmd_t bus_decode(input logic nce, input logic nwrt);
        cmd_t c;
        if (nce == 1'b0) begin
            c = (nwrt == 1'b0) ? WRITE : READ;
        end else begin
            c = IDLE;
        end
        return c;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter used for bus access statistics.
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_inc,
    output logic [CNT_W-1:0] o_cnt
);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_inc && !(&r_cnt)) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign o_cnt = r_cnt;

endmodule

// File: rtl/rf_mem_responder.sv
// Register-file memory responder: post-reset clear sweep, bus read/write, host preload.
// Define WRITE_THROUGH_EN to reflect bus write data on DO one cycle after the write.
module rf_mem_responder
    import mem_if_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              NCE,
    input  logic              NWRT,
    input  logic [RA_W-1:0]   RA,
    input  logic [CA_W-1:0]   CA,
    input  logic [DW-1:0]     DIN,
    output logic [DW-1:0]     DO,
    output logic              busy,
    input  logic              ld_valid,
    output logic              ld_ready,
    input  logic [AW-1:0]     ld_addr,
    input  logic [DW-1:0]     ld_data,
    output logic [CNT_W-1:0]  rd_cnt,
    output logic [CNT_W-1:0]  wr_cnt
);

    logic [DW-1:0] r_mem [DEPTH];
    logic [DW-1:0] r_do;
    state_t        r_state;
    state_t        w_state_nxt;
    logic [AW-1:0] r_ptr;
    logic [AW-1:0] w_ptr_nxt;

    cmd_t          w_cmd;
    logic [AW-1:0] w_addr;
    logic          w_we;
    logic [AW-1:0] w_waddr;
    logic [DW-1:0] w_wdata;
    logic          w_rd_inc;
    logic          w_wr_inc;

    assign w_cmd  = bus_decode(NCE, NWRT);
    assign w_addr = {RA, CA};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= CLEAR;
            r_ptr   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_ptr   <= w_ptr_nxt;
        end
    end

    // Single array write port shared by the clear sweep, the bus and the host
    always_comb begin
        w_state_nxt = r_state;
        w_ptr_nxt   = r_ptr;
        w_we        = 1'b0;
        w_waddr     = w_addr;
        w_wdata     = DIN;
        w_rd_inc    = 1'b0;
        w_wr_inc    = 1'b0;
        case (r_state)
            CLEAR: begin
                w_we      = 1'b1;
                w_waddr   = r_ptr;
                w_wdata   = '0;
                w_ptr_nxt = r_ptr + AW'(1);
                if (&r_ptr) begin
                    w_state_nxt = SERVE;
                end
            end
            SERVE: begin
                case (w_cmd)
                    WRITE: begin
                        w_we     = 1'b1;
                        w_wr_inc = 1'b1;
                    end
                    READ: begin
                        w_rd_inc = 1'b1;
                    end
                    default: begin
                        if (ld_valid) begin
                            w_we    = 1'b1;
                            w_waddr = ld_addr;
                            w_wdata = ld_data;
                        end
                    end
                endcase
            end
            default: begin
                w_state_nxt = CLEAR;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (w_we) begin
            r_mem[w_waddr] <= w_wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_do <= '0;
        end else if (r_state == SERVE) begin
            if (w_cmd == READ) begin
                r_do <= r_mem[w_addr];
            end
`ifdef WRITE_THROUGH_EN
            else if (w_cmd == WRITE) begin
                r_do <= DIN;
            end
`endif
        end
    end

    assign DO       = r_do;
    assign busy     = (r_state == CLEAR);
    assign ld_ready = (r_state == SERVE) && (w_cmd == IDLE);

    sat_counter #(
        .CNT_W(CNT_W)
    ) u_rd_cnt (
        .clk   (clk),
        .rst   (rst),
        .i_inc (w_rd_inc),
        .o_cnt (rd_cnt)
    );

    sat_counter #(
        .CNT_W(CNT_W)
    ) u_wr_cnt (
        .clk   (clk),
        .rst   (rst),
        .i_inc (w_wr_inc),
        .o_cnt (wr_cnt)
    );

endmodule

// File: tb/tb_rf_mem_responder.sv
// Randomized self-checking bench for rf_mem_responder against a word-array model.
// A second instance with 4-bit counters exposes saturation.
module tb_rf_mem_responder;
    import mem_if_pkg::*;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              NCE = 1'b1;
    logic              NWRT = 1'b1;
    logic [RA_W-1:0]   RA = '0;
    logic [CA_W-1:0]   CA = '0;
    logic [DW-1:0]     DIN = '0;
    logic              ld_valid = 1'b0;
    logic [AW-1:0]     ld_addr = '0;
    logic [DW-1:0]     ld_data = '0;

    logic [DW-1:0]     DO, DO_s;
    logic              busy, busy_s;
    logic              ld_ready, ld_ready_s;
    logic [15:0]       rd_cnt, wr_cnt;
    logic [3:0]        rd_s, wr_s;

    int n_cmp = 0;
    int n_err = 0;

    logic [DW-1:0] exp_mem [DEPTH];
    logic [DW-1:0] exp_do;
    int            exp_rd;
    int            exp_wr;
    bit            exp_serve;

    always #5 clk = ~clk;

    rf_mem_responder #(.CNT_W(16)) dut (
        .clk(clk), .rst(rst), .NCE(NCE), .NWRT(NWRT), .RA(RA), .CA(CA),
        .DIN(DIN), .DO(DO), .busy(busy), .ld_valid(ld_valid),
        .ld_ready(ld_ready), .ld_addr(ld_addr), .ld_data(ld_data),
        .rd_cnt(rd_cnt), .wr_cnt(wr_cnt)
    );

    rf_mem_responder #(.CNT_W(4)) dut_s (
        .clk(clk), .rst(rst), .NCE(NCE), .NWRT(NWRT), .RA(RA), .CA(CA),
        .DIN(DIN), .DO(DO_s), .busy(busy_s), .ld_valid(ld_valid),
        .ld_ready(ld_ready_s), .ld_addr(ld_addr), .ld_data(ld_data),
        .rd_cnt(rd_s), .wr_cnt(wr_s)
    );

    function automatic int sat15(input int v);
        return (v > 15) ? 15 : v;
    endfunction

    function automatic logic [DW-1:0] rnd_word();
        return DW'({$urandom, $urandom});
    endfunction

    // One clock edge: advance the model with the inputs sampled at that edge
    task automatic step();
        bit            rdy;
        bit            acc;
        logic [AW-1:0] a;
        rdy = exp_serve && (NCE === 1'b1);
        a   = {RA, CA};
        acc = 1'b0;
        @(posedge clk);
        if (exp_serve) begin
            if (NCE === 1'b0) begin
                if (NWRT) begin
                    exp_do = exp_mem[a];
                    exp_rd++;
                end else begin
                    exp_mem[a] = DIN;
                    exp_wr++;
`ifdef WRITE_THROUGH_EN
                    exp_do = DIN;
`endif
                end
            end else if (ld_valid && rdy) begin
                exp_mem[ld_addr] = ld_data;
                acc = 1'b1;
            end
        end
        #1;
        if (acc) ld_valid = 1'b0;
    endtask

    task automatic bus_read(input logic [AW-1:0] a);
        NCE = 1'b0; NWRT = 1'b1; {RA, CA} = a;
    endtask

    task automatic bus_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
        NCE = 1'b0; NWRT = 1'b0; {RA, CA} = a; DIN = d;
    endtask

    task automatic bus_idle();
        NCE = 1'b1; NWRT = 1'b1;
    endtask

    task automatic reset_and_sweep(input string tag);
        int n;
        rst = 1'b1; bus_idle(); ld_valid = 1'b0;
        exp_serve = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        n = 0;
        while (busy === 1'b1 && n < 200) begin
            step();
            n++;
        end
        n_cmp++;
        if (n != 128) begin
            n_err++;
            $display("FAIL %s_sweep_len cycles=%0d expected=128", tag, n);
        end
        for (int i = 0; i < DEPTH; i++) exp_mem[i] = '0;
        exp_do = '0; exp_rd = 0; exp_wr = 0;
        exp_serve = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if ({DO, busy, ld_ready, rd_cnt, wr_cnt} !== {{DW{1'b0}}, 1'b1, 1'b0, 32'd0}) begin
            n_err++;
            $display("FAIL reset_vals DO=%h busy=%b rdy=%b rd=%0d wr=%0d required 0/1/0/0/0",
                     DO, busy, ld_ready, rd_cnt, wr_cnt);
        end
        reset_and_sweep("reset");
    endtask

    task automatic test_clear_reads();
        for (int a = 0; a < DEPTH; a++) begin
            bus_read(AW'(a));
            step();
            n_cmp++;
            if (DO !== '0) begin
                n_err++;
                $display("FAIL clear_read addr=%0d DO=%h required 0", a, DO);
            end
        end
        bus_idle();
        n_cmp++;
        if (rd_cnt !== 16'd128 || wr_cnt !== 16'd0 || rd_s !== 4'd15) begin
            n_err++;
            $display("FAIL clear_cnt rd=%0d wr=%0d rd_s=%0d required 128/0/15",
                     rd_cnt, wr_cnt, rd_s);
        end
    endtask

    task automatic test_host_load();
        bus_idle();
        ld_valid = 1'b1; ld_addr = 7'h25; ld_data = 52'hA_5A5A5_1234;
        #1;
        n_cmp++;
        if (ld_ready !== 1'b1) begin
            n_err++;
            $display("FAIL host_ready ld_ready=%b required 1", ld_ready);
        end
        step();
        n_cmp++;
        if (ld_valid !== 1'b0) begin
            n_err++;
            $display("FAIL host_accept model did not accept");
        end
        NCE = 1'b0; NWRT = 1'b1; RA = 5'd9; CA = 2'd1;
        step();
        bus_idle();
        n_cmp++;
        if (DO !== 52'hA_5A5A5_1234 || DO !== exp_do) begin
            n_err++;
            $display("FAIL host_readback DO=%h required %h", DO, 52'hA_5A5A5_1234);
        end
    endtask

    task automatic test_priority();
        int rd0;
        int wr0;
        ld_valid = 1'b1; ld_addr = AW'($urandom); ld_data = rnd_word();
        for (int i = 0; i < 6; i++) begin
            bus_read(AW'($urandom));
            #1;
            n_cmp++;
            if (ld_ready !== 1'b0) begin
                n_err++;
                $display("FAIL prio_ready cyc=%0d ld_ready=%b required 0", i, ld_ready);
            end
            step();
            n_cmp++;
            if (DO !== exp_do) begin
                n_err++;
                $display("FAIL prio_read cyc=%0d DO=%h required %h", i, DO, exp_do);
            end
        end
        bus_idle();
        #1;
        n_cmp++;
        if (ld_ready !== 1'b1) begin
            n_err++;
            $display("FAIL prio_gap ld_ready=%b required 1", ld_ready);
        end
        rd0 = exp_rd; wr0 = exp_wr;
        step();
        n_cmp++;
        if (rd_cnt !== 16'(rd0) || wr_cnt !== 16'(wr0)) begin
            n_err++;
            $display("FAIL prio_cnt rd=%0d wr=%0d required %0d/%0d", rd_cnt, wr_cnt, rd0, wr0);
        end
        bus_read(ld_addr);
        step();
        bus_idle();
        n_cmp++;
        if (DO !== exp_do) begin
            n_err++;
            $display("FAIL prio_load DO=%h required %h", DO, exp_do);
        end
    endtask

    task automatic test_back_to_back();
        logic [DW-1:0] prior;
        prior = exp_do;
        bus_write(AW'(0), 52'h3);
        step();
        n_cmp++;
`ifdef WRITE_THROUGH_EN
        if (DO !== 52'h3) begin
            n_err++;
            $display("FAIL b2b_wt DO=%h required %h", DO, 52'h3);
        end
`else
        if (DO !== prior) begin
            n_err++;
            $display("FAIL b2b_hold DO=%h required %h", DO, prior);
        end
`endif
        bus_read(AW'(0));
        step();
        bus_idle();
        n_cmp++;
        if (DO !== 52'h3 || rd_cnt !== 16'(exp_rd) || wr_cnt !== 16'(exp_wr)) begin
            n_err++;
            $display("FAIL b2b_raw DO=%h rd=%0d wr=%0d required 3/%0d/%0d",
                     DO, rd_cnt, wr_cnt, exp_rd, exp_wr);
        end
    endtask

    task automatic test_random();
        int bad;
        bad = 0;
        for (int i = 0; i < 400; i++) begin
            if (!ld_valid && ($urandom_range(0, 3) == 0)) begin
                ld_valid = 1'b1; ld_addr = AW'($urandom); ld_data = rnd_word();
            end
            if ($urandom_range(0, 1) == 0) begin
                bus_idle();
            end else if ($urandom_range(0, 1) == 0) begin
                bus_write(AW'($urandom_range(0, 15)), rnd_word());
            end else begin
                bus_read(AW'($urandom_range(0, 15)));
            end
            #1;
            n_cmp++;
            if (ld_ready !== NCE) begin
                n_err++;
                if (bad++ < 5) $display("FAIL rnd_ready cyc=%0d got=%b required %b", i, ld_ready, NCE);
            end
            step();
            n_cmp++;
            if (DO !== exp_do || rd_cnt !== 16'(exp_rd) || wr_cnt !== 16'(exp_wr)
                || wr_s !== 4'(sat15(exp_wr))) begin
                n_err++;
                if (bad++ < 5)
                    $display("FAIL rnd_out cyc=%0d DO=%h/%h rd=%0d/%0d wr=%0d/%0d",
                             i, DO, exp_do, rd_cnt, exp_rd, wr_cnt, exp_wr);
            end
        end
        bus_idle();
        for (int i = 0; i < 4 && ld_valid; i++) step();
    endtask

    task automatic test_saturation();
        for (int i = 0; i < 20; i++) begin
            bus_read(AW'($urandom));
            step();
        end
        bus_idle();
        n_cmp++;
        if (rd_s !== 4'd15 || rd_cnt !== 16'(exp_rd) || wr_s !== 4'(sat15(exp_wr))) begin
            n_err++;
            $display("FAIL sat rd_s=%0d rd=%0d/%0d wr_s=%0d required 15",
                     rd_s, rd_cnt, exp_rd, wr_s);
        end
    endtask

    task automatic test_reset_mid();
        logic [DW-1:0] pat;
        pat = rnd_word() | 52'h1;
        bus_write(AW'(10), pat);
        step();
        bus_read(AW'(10));
        step();
        n_cmp++;
        if (DO !== pat) begin
            n_err++;
            $display("FAIL mid_pre DO=%h required %h", DO, pat);
        end
        #3;
        rst = 1'b1;
        #1;
        n_cmp++;
        if (DO !== '0 || busy !== 1'b1 || ld_ready !== 1'b0 || rd_cnt !== '0 || wr_cnt !== '0) begin
            n_err++;
            $display("FAIL mid_async DO=%h busy=%b rdy=%b rd=%0d wr=%0d required 0/1/0/0/0",
                     DO, busy, ld_ready, rd_cnt, wr_cnt);
        end
        reset_and_sweep("mid");
        bus_read(AW'(10));
        step();
        bus_idle();
        n_cmp++;
        if (DO !== '0) begin
            n_err++;
            $display("FAIL mid_cleared DO=%h required 0", DO);
        end
    endtask

    initial begin
        test_reset();
        test_clear_reads();
        test_host_load();
        test_priority();
        test_back_to_back();
        test_random();
        test_saturation();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
